// File: rtl/alu_pkg.sv
// Opcode set shared by the 32-bit ALU and its sequencing controller.
package alu_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2,
        OP_AND = 5'd3,
        OP_OR  = 5'd4,
        OP_XOR = 5'd5,
        OP_NOR = 5'd6
    } alu_op_e;

    // Opcodes above NOR are reserved and rejected by the controller.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_NOR;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Result stream plus ALU operand/result bus between the sequencer and its neighbours.
interface alu_seq_ctrl_if #(
    parameter int DATA_W = 32
) ();

    logic [DATA_W-1:0]        result;
    logic                     result_valid;
    logic                     result_ready;
    logic [DATA_W-1:0]        alu_a;
    logic [DATA_W-1:0]        alu_b;
    logic [alu_pkg::OP_W-1:0] alu_op;
    logic [DATA_W-1:0]        alu_out;

    modport master (
        output result, result_valid, alu_a, alu_b, alu_op,
        input  result_ready, alu_out
    );

    modport slave (
        input  result, result_valid, alu_a, alu_b, alu_op,
        output result_ready, alu_out
    );

endinterface

// File: rtl/alu_seq_ctrl.sv
// Iterates x[k+2] = x[k+1] op x[k] through an external combinational ALU and
// streams each term out on a valid/ready handshake.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] seed_a,
    input  logic [DATA_W-1:0] seed_b,
    input  logic [OP_W-1:0]   op,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    alu_seq_ctrl_if.master    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    state_e            r_state;
    logic [DATA_W-1:0] r_prev;
    logic [DATA_W-1:0] r_cur;
    logic [DATA_W-1:0] r_result;
    logic              r_valid;
    logic [OP_W-1:0]   r_op;
    logic [OP_W-1:0]   r_alu_op;
    logic [CNT_W-1:0]  r_rem;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_start_ok;
    logic              w_hs;

    assign w_start_ok = op_is_legal(op) && (count != '0);
    // r_valid is only ever set while in HOLD, so this is the HOLD handshake.
    assign w_hs       = r_valid && bus.result_ready;

    // Operands always reflect the recurrence registers; only alu_op is gated to ISSUE.
    assign bus.alu_a        = r_cur;
    assign bus.alu_b        = r_prev;
    assign bus.alu_op       = r_alu_op;
    assign bus.result       = r_result;
    assign bus.result_valid = r_valid;
    assign busy             = r_busy;
    assign done             = r_done;
    assign err              = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_prev   <= '0;
            r_cur    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
            r_op     <= OP_NOP;
            r_alu_op <= OP_NOP;
            r_rem    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_start_ok) begin
                            r_prev   <= seed_a;
                            r_cur    <= seed_b;
                            r_op     <= op;
                            r_alu_op <= op;
                            r_rem    <= count;
                            r_err    <= 1'b0;
                            r_state  <= S_ISSUE;
                        end else begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end
                    end
                end
                S_ISSUE: begin
                    r_result <= bus.alu_out;
                    r_valid  <= 1'b1;
                    r_alu_op <= OP_NOP;
                    r_state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (w_hs) begin
                        r_prev  <= r_cur;
                        r_cur   <= r_result;
                        r_rem   <= r_rem - 1'b1;
                        r_valid <= 1'b0;
                        // Ending at rem==1 keeps rem from ever wrapping below zero.
                        if (r_rem == CNT_W'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            r_alu_op <= r_op;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
